// File: rtl/alu_req_dispatcher_pkg.sv
// Shared types and width constants for the ALU request dispatcher and its FIFO.
package alu_disp_pkg;

  localparam int OPERAND_MAX_DATA_WIDTH = 8;
  localparam int DATA_W     = OPERAND_MAX_DATA_WIDTH;
  localparam int OP_W       = 3;
  localparam int DISP_DEPTH = 4;
  localparam int DISP_TAG_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } disp_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
  } alu_req_t;

endpackage

// File: rtl/alu_req_dispatcher_fifo.sv
// Request buffer: DEPTH entries of alu_req_t, head visible on dout_o (show-ahead).
module alu_req_fifo
  import alu_disp_pkg::*;
#(
  parameter int DEPTH = DISP_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  alu_req_t                 din_i,
  input  logic                     pop_i,
  output alu_req_t                 dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  alu_req_t             mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A full FIFO never accepts, even when a pop happens in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset: a flush only needs the pointers and count cleared.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/alu_req_dispatcher.sv
// Buffers ALU requests and issues them one at a time with a start pulse and a
// wrap-around tag, waiting for the ALU done pulse between issues.
//
// Handshake: a request transfers at a rising edge where req_valid && req_ready;
// req_ready depends only on occupancy, never on req_valid.
module alu_req_dispatcher
  import alu_disp_pkg::*;
#(
  parameter int DEPTH = DISP_DEPTH,
  parameter int TAG_W = DISP_TAG_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [DATA_W-1:0]        req_a,
  input  logic [DATA_W-1:0]        req_b,
  input  logic [OP_W-1:0]          req_op,
  output logic                     alu_start,
  output logic [DATA_W-1:0]        alu_a,
  output logic [DATA_W-1:0]        alu_b,
  output logic [OP_W-1:0]          alu_op,
  output logic [TAG_W-1:0]         alu_tag,
  input  logic                     alu_done,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     busy,
  output logic                     err_spurious,
  output disp_state_t              dbg_state
);

  disp_state_t          state_q, state_d;
  alu_req_t             head;
  alu_req_t             push_req;
  logic                 fifo_full, fifo_empty;
  logic                 issue;
  logic [DATA_W-1:0]    alu_a_q, alu_b_q;
  logic [OP_W-1:0]      alu_op_q;
  logic [TAG_W-1:0]     alu_tag_q, tag_cnt_q;
  logic                 err_q, err_d;

  assign push_req = '{a: req_a, b: req_b, op: req_op};

  alu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (req_valid && !fifo_full),
    .din_i   (push_req),
    .pop_i   (issue),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (occupancy)
  );

  // issue marks the edge entering ISSUE: the head is loaded and popped there.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = ISSUE;
          issue   = 1'b1;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (alu_done) begin
          if (!fifo_empty) begin
            state_d = ISSUE;
            issue   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign err_d = err_q || (alu_done && (state_q != WAIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_op_q  <= '0;
      alu_tag_q <= '0;
      tag_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (issue) begin
        alu_a_q   <= head.a;
        alu_b_q   <= head.b;
        alu_op_q  <= head.op;
        alu_tag_q <= tag_cnt_q;
        tag_cnt_q <= tag_cnt_q + TAG_W'(1);
      end
    end
  end

  assign req_ready    = !fifo_full;
  assign alu_start    = (state_q == ISSUE);
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_op       = alu_op_q;
  assign alu_tag      = alu_tag_q;
  assign busy         = (state_q != IDLE) || (occupancy != '0);
  assign err_spurious = err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_alu_req_dispatcher.sv
// Self-checking bench: directed scenarios plus random traffic, checked every
// cycle against a queue-based transaction model of the dispatcher.
module tb_alu_req_dispatcher;
  import alu_disp_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int RW    = 2*DATA_W + OP_W;
  localparam int SW    = TAG_W + RW;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   req_valid = 1'b0;
  logic                   req_ready;
  logic [DATA_W-1:0]      req_a = '0, req_b = '0;
  logic [OP_W-1:0]        req_op = '0;
  logic                   alu_start;
  logic [DATA_W-1:0]      alu_a, alu_b;
  logic [OP_W-1:0]        alu_op;
  logic [TAG_W-1:0]       alu_tag;
  logic                   alu_done = 1'b0;
  logic [$clog2(DEPTH):0] occupancy;
  logic                   busy;
  logic                   err_spurious;
  disp_state_t            dbg_state;

  alu_req_dispatcher #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_op       (req_op),
    .alu_start    (alu_start),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_tag      (alu_tag),
    .alu_done     (alu_done),
    .occupancy    (occupancy),
    .busy         (busy),
    .err_spurious (err_spurious),
    .dbg_state    (dbg_state)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
  endtask

  // Transaction model: pending queue, whether the ALU owns an op, and whether
  // that op was issued on the most recent edge (its start cycle).
  logic [RW-1:0]     m_q[$];
  logic [SW-1:0]     exp_q[$];
  bit                m_inflight = 0;
  bit                m_start    = 0;
  bit                m_err      = 0;
  logic [DATA_W-1:0] m_a = '0, m_b = '0;
  logic [OP_W-1:0]   m_op = '0;
  logic [TAG_W-1:0]  m_tag = '0, m_tagcnt = '0;

  task automatic cycle();
    bit done_ok, do_issue, do_push;
    logic [RW-1:0] r;
    logic [SW-1:0] e;
    @(posedge clk);
    if (rst) begin
      m_q.delete(); exp_q.delete();
      m_inflight = 0; m_start = 0; m_err = 0;
      m_a = '0; m_b = '0; m_op = '0; m_tag = '0; m_tagcnt = '0;
    end else begin
      done_ok  = alu_done && m_inflight && !m_start;
      if (alu_done && !done_ok) m_err = 1;
      do_issue = (m_q.size() > 0) && (!m_inflight || done_ok);
      do_push  = req_valid && (m_q.size() < DEPTH);
      if (do_issue) begin
        r = m_q.pop_front();
        {m_a, m_b, m_op} = r;
        m_tag = m_tagcnt;
        m_tagcnt = m_tagcnt + 1'b1;
        exp_q.push_back({m_tag, r});
        m_inflight = 1; m_start = 1;
      end else begin
        m_start = 0;
        if (done_ok) m_inflight = 0;
      end
      if (do_push) m_q.push_back({req_a, req_b, req_op});
    end
    #1;
    chk("start", alu_start, m_start);
    chk("occupancy", occupancy, m_q.size());
    chk("req_ready", req_ready, m_q.size() < DEPTH);
    chk("busy", busy, m_inflight || (m_q.size() != 0));
    chk("err_spurious", err_spurious, m_err);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("alu_op", alu_op, m_op);
    chk("alu_tag", alu_tag, m_tag);
    if (alu_start) begin
      chk("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_issue", {alu_tag, alu_a, alu_b, alu_op}, e);
      end
    end
  endtask

  task automatic push_req(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                          input logic [OP_W-1:0] op);
    req_valid = 1'b1; req_a = a; req_b = b; req_op = op;
    cycle();
    req_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) cycle();
    rst = 1'b0;
  endtask

  // Pulse alu_done once the ALU is past its start cycle; bounded wait.
  task automatic done_when_waiting();
    for (int i = 0; i < 40; i++) begin
      if (m_inflight && !m_start) begin
        alu_done = 1'b1;
        cycle();
        alu_done = 1'b0;
        return;
      end
      cycle();
    end
    chk("done_wait_timeout", 0, 1);
  endtask

  initial begin
    // 1. Reset
    do_reset(2);
    chk("rst_start", alu_start, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_tag", alu_tag, 0);
    chk("rst_err", err_spurious, 0);

    // 2. Single op, no bypass: start appears one edge after the push edge
    push_req(8'd255, 8'd255, 3'd0);
    chk("single_nostart_yet", alu_start, 0);
    cycle();
    chk("single_start", alu_start, 1);
    chk("single_a", alu_a, 255);
    chk("single_b", alu_b, 255);
    chk("single_tag", alu_tag, 0);
    repeat (4) cycle();
    alu_done = 1'b1; cycle(); alu_done = 1'b0;
    chk("single_idle_busy", busy, 0);

    // 3. Fill with done held low until the FIFO is full and pushes stall
    req_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      req_a = DATA_W'($urandom); req_b = DATA_W'($urandom); req_op = OP_W'($urandom);
      cycle();
    end
    req_valid = 1'b0;
    chk("fill_occ_full", occupancy, DEPTH);
    chk("fill_ready_low", req_ready, 0);
    cycle();

    // 4. Back-to-back issue after reset: tags 0,1,2 with no IDLE bubble
    do_reset(1);
    for (int i = 0; i < 3; i++) push_req(DATA_W'(i + 10), DATA_W'(i + 20), OP_W'(i));
    for (int i = 1; i < 3; i++) begin
      done_when_waiting();
      chk("b2b_start", alu_start, 1);
      chk("b2b_tag", alu_tag, i);
      chk("b2b_a", alu_a, i + 10);
    end
    done_when_waiting();
    cycle();

    // 5. Tag wrap across 17 ops
    do_reset(1);
    for (int i = 0; i < 17; i++) begin
      push_req(DATA_W'($urandom), DATA_W'($urandom), OP_W'($urandom));
      cycle();
      chk("wrap_start", alu_start, 1);
      chk("wrap_tag", alu_tag, i % 16);
      done_when_waiting();
    end
    cycle();

    // 6. Spurious done in IDLE, then reset mid-WAIT with 2 queued
    alu_done = 1'b1; cycle(); alu_done = 1'b0;
    chk("spur_set", err_spurious, 1);
    repeat (3) cycle();
    chk("spur_hold", err_spurious, 1);
    for (int i = 0; i < 3; i++) push_req(DATA_W'($urandom), DATA_W'($urandom), OP_W'($urandom));
    cycle();
    chk("midop_queued", occupancy, 2);
    do_reset(1);
    chk("midop_occ", occupancy, 0);
    chk("midop_busy", busy, 0);
    chk("midop_err", err_spurious, 0);
    alu_done = 1'b1; cycle(); alu_done = 1'b0;
    chk("post_rst_spur", err_spurious, 1);

    // 7. Random traffic with occasional reset
    do_reset(1);
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      req_valid = ($urandom_range(0, 1) == 1);
      req_a     = DATA_W'($urandom);
      req_b     = DATA_W'($urandom);
      req_op    = OP_W'($urandom);
      alu_done  = ($urandom_range(0, 4) == 0);
      cycle();
    end
    rst = 1'b0; req_valid = 1'b0; alu_done = 1'b0;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
